ps2_key_tracker: RTL and testbench
==================================

# ps2_key_tracker

Scan-code interpreter between the PS/2 controller's received-byte strobe and the game logic. Decodes Set-2 make/break sequences (including E0 extended and E1 pause prefixes) into a live held-key bitmap for eight game keys. Queues key-press events in a 4-deep FIFO with a valid/ready handshake. Typematic repeats never generate events.

## Interface
- TIMEOUT_CYCLES, 1_000_000: CLOCK_50 cycles (20 ms) a prefix state may wait for its next byte before abandoning the sequence; counter width sized to hold it.
- CLOCK_50  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- received_data  in  8  scan byte from the PS/2 controller; valid only when received_data_en=1.
- received_data_en  in  1  single-cycle strobe, one per received byte.
- keys_held  out  8  bit set while the key is down: 0 W(1D), 1 A(1C), 2 S(1B), 3 D(23), 4 Space(29), 5 Enter(5A), 6 Esc(76), 7 R(2D).
- evt_key  out  3  index of the oldest queued press event.
- evt_valid  out  1  FIFO non-empty.
- evt_ready  in  1  consumer accepts; pop when evt_valid & evt_ready.
- evt_overflow  out  1  sticky; set when a press event is dropped on a full FIFO.

## Operation
- Decoder FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), SKIP (E1 seen).
- IDLE: E0->EXT, F0->BRK, E1->SKIP with skip count 7. A tracked code is a make for its bit. Any other byte is ignored.
- EXT: F0->EXT_BRK. Any other byte is an extended make, then go to IDLE.
- BRK: a tracked code is a break for its bit. Any byte (tracked or not) then returns to IDLE.
- EXT_BRK: any byte is an extended break, then go to IDLE.
- SKIP: decrement count on each strobe. Return to IDLE after the 7th byte. The E1 pause sequence affects nothing.
- Prefix timeout: the counter runs in EXT/BRK/EXT_BRK/SKIP and clears on every strobe. Reaching TIMEOUT_CYCLES forces IDLE with no effect on keys_held or the FIFO.
- Held state is kept in two 8-bit registers, base and ext. keys_held = base | ext.
- A make sets its bit. A break clears it.
- Press event: a make whose bit was 0 in keys_held before the update pushes that bit index. A make with the bit already 1 (typematic, or alias already held) pushes nothing.
- Break bytes never push.
- FIFO: depth 4, count 0..4.
  - A push is accepted if count<4, or if a pop occurs in the same cycle.
  - Otherwise the event is dropped and evt_overflow is set.
  - Simultaneous push and pop at count 0 is impossible (evt_valid=0). At count 4 the pop is applied and the push is stored, so count stays 4.
- Pointers wrap modulo 4. Order is strictly FIFO.
- Reset mid-sequence: FSM returns to IDLE; base, ext, FIFO, count and overflow all clear.

## Timing
- Reset values: keys_held=8'h00, evt_key=3'd0, evt_valid=0, evt_overflow=0.
- A strobe in cycle N updates keys_held at N+1.
- A pushed event is visible at N+1 when the FIFO was empty (evt_key registered from the head entry).
- A pop in cycle N advances evt_key/evt_valid at N+1.
- One byte is processed per strobe. Back-to-back strobes on consecutive cycles are supported.
- Timeout fires on the cycle the counter equals TIMEOUT_CYCLES-1; FSM is IDLE the next cycle.

## Configuration
- PS2_ARROW_ALIAS_EN defined: extended makes/breaks map into the ext register. E0 75 (up)->bit0, E0 6B (left)->bit1, E0 72 (down)->bit2, E0 74 (right)->bit3. Other extended codes are ignored.
- PS2_ARROW_ALIAS_EN undefined: ext stays 8'h00. E0 sequences are parsed and consumed with no effect on keys_held or the FIFO.
- Non-extended 75/6B/72/74 (keypad) are never tracked.

## Test plan
- Bytes 1D, F0 1D -> keys_held[0] 1 then 0; exactly one event, evt_key=0; evt_overflow=0.
- Bytes 1D, 1D, 1D (typematic) with evt_ready=0 -> keys_held=8'h01; FIFO count 1.
- With alias: E0 75, then 1D, then E0 F0 75 -> bit0 set after the first make; only one event (the second make finds the bit already held); bit0 stays 1 after the arrow break, because base still holds it.
- evt_ready=0, makes for W,A,S,D,Space -> evt_key sequence 0,1,2,3 and evt_overflow=1; with push and pop in the same cycle at count 4 -> no overflow, count stays 4.
- E1 14 77 E1 F0 14 F0 77 -> keys_held and FIFO unchanged; FSM IDLE afterwards; a following 29 sets bit4.
- Byte F0, then idle TIMEOUT_CYCLES, then 1D -> treated as a make (bit0=1, event 0). Reset asserted mid E0 F0 -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ps2_key_tracker.sv
// Set-2 scan-code decoder: held-key bitmap for eight game keys plus a 4-deep press-event FIFO.
// Define PS2_ARROW_ALIAS_EN to map the E0 arrow keys onto the W/A/S/D bits.
module ps2_key_tracker #(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [7:0] received_data,
   input  logic       received_data_en,
   output logic [7:0] keys_held,
   output logic [2:0] evt_key,
   output logic       evt_valid,
   input  logic       evt_ready,
   output logic       evt_overflow
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK, ST_SKIP} state_t;

   state_t           state_q, state_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [2:0]       skip_q, skip_d;
   logic [7:0]       base_q, base_d, ext_q, ext_d;
   logic [2:0]       mem_q [4];
   logic [2:0]       mem_d [4];
   logic [1:0]       wr_q, wr_d, rd_q, rd_d;
   logic [2:0]       count_q, count_d;
   logic [2:0]       evt_key_q, evt_key_d;
   logic             evt_valid_q, evt_valid_d, ovf_q, ovf_d;

   logic       make, brk, use_ext, push, pop, accept;
   logic [2:0] idx;
   logic [3:0] lk;

   // {hit, bit index}
   function automatic logic [3:0] base_lookup(input logic [7:0] code);
      case (code)
         8'h1D:   base_lookup = 4'b1_000;
         8'h1C:   base_lookup = 4'b1_001;
         8'h1B:   base_lookup = 4'b1_010;
         8'h23:   base_lookup = 4'b1_011;
         8'h29:   base_lookup = 4'b1_100;
         8'h5A:   base_lookup = 4'b1_101;
         8'h76:   base_lookup = 4'b1_110;
         8'h2D:   base_lookup = 4'b1_111;
         default: base_lookup = 4'b0_000;
      endcase
   endfunction

`ifdef PS2_ARROW_ALIAS_EN
   function automatic logic [3:0] arrow_lookup(input logic [7:0] code);
      case (code)
         8'h75:   arrow_lookup = 4'b1_000;
         8'h6B:   arrow_lookup = 4'b1_001;
         8'h72:   arrow_lookup = 4'b1_010;
         8'h74:   arrow_lookup = 4'b1_011;
         default: arrow_lookup = 4'b0_000;
      endcase
   endfunction
`endif

   assign keys_held    = base_q | ext_q;
   assign evt_key      = evt_key_q;
   assign evt_valid    = evt_valid_q;
   assign evt_overflow = ovf_q;

   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      skip_d  = skip_q;
      base_d  = base_q;
      ext_d   = ext_q;
      make    = 1'b0;
      brk     = 1'b0;
      use_ext = 1'b0;
      lk      = base_lookup(received_data);
      idx     = lk[2:0];

      if (received_data_en) begin
         tmo_d = '0;
         case (state_q)
            ST_IDLE: begin
               if (received_data == 8'hE0) state_d = ST_EXT;
               else if (received_data == 8'hF0) state_d = ST_BRK;
               else if (received_data == 8'hE1) begin
                  state_d = ST_SKIP;
                  skip_d  = 3'd7;
               end else make = lk[3];
            end
            ST_EXT: begin
               if (received_data == 8'hF0) state_d = ST_EXT_BRK;
               else begin
                  state_d = ST_IDLE;
`ifdef PS2_ARROW_ALIAS_EN
                  lk      = arrow_lookup(received_data);
                  idx     = lk[2:0];
                  make    = lk[3];
                  use_ext = 1'b1;
`endif
               end
            end
            ST_BRK: begin
               brk     = lk[3];
               state_d = ST_IDLE;
            end
            ST_EXT_BRK: begin
               state_d = ST_IDLE;
`ifdef PS2_ARROW_ALIAS_EN
               lk      = arrow_lookup(received_data);
               idx     = lk[2:0];
               brk     = lk[3];
               use_ext = 1'b1;
`endif
            end
            ST_SKIP: begin
               if (skip_q == 3'd1) state_d = ST_IDLE;
               skip_d = skip_q - 3'd1;
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (state_q != ST_IDLE) begin
         // A strobe on the expiry cycle wins; otherwise an abandoned prefix drops back silently.
         if (tmo_q == TMO_LAST) begin
            state_d = ST_IDLE;
            tmo_d   = '0;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end

      push = make & ~keys_held[idx];
      if (make) begin
         if (use_ext) ext_d[idx] = 1'b1;
         else         base_d[idx] = 1'b1;
      end
      if (brk) begin
         if (use_ext) ext_d[idx] = 1'b0;
         else         base_d[idx] = 1'b0;
      end
   end

   always_comb begin
      mem_d  = mem_q;
      wr_d   = wr_q;
      ovf_d  = ovf_q;
      accept = 1'b0;
      pop    = evt_valid_q & evt_ready;
      rd_d   = pop ? rd_q + 2'd1 : rd_q;
      if (push) begin
         if (count_q != 3'd4 || pop) begin
            mem_d[wr_q] = idx;
            wr_d        = wr_q + 2'd1;
            accept      = 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end
      count_d     = count_q + 3'(accept) - 3'(pop);
      evt_key_d   = mem_d[rd_d];
      evt_valid_d = (count_d != 3'd0);
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         tmo_q       <= '0;
         skip_q      <= '0;
         base_q      <= '0;
         ext_q       <= '0;
         mem_q       <= '{default: '0};
         wr_q        <= '0;
         rd_q        <= '0;
         count_q     <= '0;
         evt_key_q   <= '0;
         evt_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         tmo_q       <= tmo_d;
         skip_q      <= skip_d;
         base_q      <= base_d;
         ext_q       <= ext_d;
         mem_q       <= mem_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         count_q     <= count_d;
         evt_key_q   <= evt_key_d;
         evt_valid_q <= evt_valid_d;
         ovf_q       <= ovf_d;
      end
   end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker with a shortened prefix timeout.
module tb_ps2_key_tracker;

   localparam int unsigned TMO = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_en;
   logic       ready;
   logic [7:0] keys_held;
   logic [2:0] evt_key;
   logic       evt_valid;
   logic       evt_overflow;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ps2_key_tracker #(.TIMEOUT_CYCLES(TMO)) dut (
      .CLOCK_50        (clk),
      .reset           (rst),
      .received_data   (rx_data),
      .received_data_en(rx_en),
      .keys_held       (keys_held),
      .evt_key         (evt_key),
      .evt_valid       (evt_valid),
      .evt_ready       (ready),
      .evt_overflow    (evt_overflow)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_data = b;
      rx_en   = 1'b1;
      tick();
      rx_en   = 1'b0;
   endtask

   task automatic pop();
      ready = 1'b1;
      tick();
      ready = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
   logic [7:0] wasds [5] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29};

   initial begin
      rst = 1'b1; rx_data = '0; rx_en = 1'b0; ready = 1'b0;
      #1;
      tick(); tick();
      chk("rst_keys", keys_held, 8'h00);
      chk("rst_key", {5'd0, evt_key}, 8'd0);
      chk("rst_valid", {7'd0, evt_valid}, 8'd0);
      chk("rst_ovf", {7'd0, evt_overflow}, 8'd0);
      rst = 1'b0;
      tick();

      // make then break of W
      send(8'h1D);
      chk("w_make_keys", keys_held, 8'h01);
      chk("w_make_valid", {7'd0, evt_valid}, 8'd1);
      chk("w_make_key", {5'd0, evt_key}, 8'd0);
      send(8'hF0); send(8'h1D);
      chk("w_brk_keys", keys_held, 8'h00);
      pop();
      chk("w_one_evt", {7'd0, evt_valid}, 8'd0);
      chk("w_ovf", {7'd0, evt_overflow}, 8'd0);

      // typematic: one event only
      send(8'h1D); send(8'h1D); send(8'h1D);
      chk("typ_keys", keys_held, 8'h01);
      chk("typ_key", {5'd0, evt_key}, 8'd0);
      pop();
      chk("typ_count1", {7'd0, evt_valid}, 8'd0);
      send(8'hF0); send(8'h1D);
      chk("typ_brk_keys", keys_held, 8'h00);
      chk("typ_brk_nopush", {7'd0, evt_valid}, 8'd0);

      // fill past depth
      foreach (wasds[i]) send(wasds[i]);
      chk("fill_keys", keys_held, 8'h1F);
      chk("fill_ovf", {7'd0, evt_overflow}, 8'd1);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("fill_order%0d", i), {5'd0, evt_key}, 8'(i));
         pop();
      end
      chk("fill_empty", {7'd0, evt_valid}, 8'd0);

      // asynchronous reset in the middle of E0 F0
      send(8'hE0); send(8'hF0);
      #2 rst = 1'b1;
      #1;
      chk("arst_keys", keys_held, 8'h00);
      chk("arst_key", {5'd0, evt_key}, 8'd0);
      chk("arst_valid", {7'd0, evt_valid}, 8'd0);
      chk("arst_ovf", {7'd0, evt_overflow}, 8'd0);
      rst = 1'b0;
      tick();
      send(8'h1D);
      chk("arst_idle_make", keys_held, 8'h01);

      // push and pop together at count 4
      do_reset();
      for (int i = 0; i < 4; i++) send(wasds[i]);
      chk("full_head", {5'd0, evt_key}, 8'd0);
      rx_data = 8'h29; rx_en = 1'b1; ready = 1'b1;
      tick();
      rx_en = 1'b0; ready = 1'b0;
      chk("pp_ovf", {7'd0, evt_overflow}, 8'd0);
      chk("pp_keys", keys_held, 8'h1F);
      for (int i = 1; i < 5; i++) begin
         chk($sformatf("pp_order%0d", i), {5'd0, evt_key}, 8'(i));
         pop();
      end
      chk("pp_empty", {7'd0, evt_valid}, 8'd0);

      // E1 pause sequence is swallowed
      do_reset();
      foreach (pause_seq[i]) send(pause_seq[i]);
      chk("pause_keys", keys_held, 8'h00);
      chk("pause_valid", {7'd0, evt_valid}, 8'd0);
      send(8'h29);
      chk("pause_after_keys", keys_held, 8'h10);
      chk("pause_after_key", {5'd0, evt_key}, 8'd4);

      // prefix timeout boundaries
      do_reset();
      send(8'h1D);
      pop();
      send(8'hF0);
      repeat (TMO - 2) tick();
      send(8'h1D);
      chk("tmo_before_brk", keys_held, 8'h00);
      send(8'hF0);
      repeat (TMO) tick();
      send(8'h1D);
      chk("tmo_after_make", keys_held, 8'h01);
      chk("tmo_after_valid", {7'd0, evt_valid}, 8'd1);
      chk("tmo_after_key", {5'd0, evt_key}, 8'd0);

      // extended codes
      do_reset();
`ifdef PS2_ARROW_ALIAS_EN
      send(8'hE0); send(8'h75);
      chk("al_up_keys", keys_held, 8'h01);
      chk("al_up_key", {5'd0, evt_key}, 8'd0);
      send(8'h1D);
      chk("al_w_keys", keys_held, 8'h01);
      pop();
      chk("al_one_evt", {7'd0, evt_valid}, 8'd0);
      send(8'hE0); send(8'hF0); send(8'h75);
      chk("al_upbrk_keys", keys_held, 8'h01);
      send(8'hF0); send(8'h1D);
      chk("al_wbrk_keys", keys_held, 8'h00);
      send(8'hE0); send(8'h6B);
      chk("al_left_keys", keys_held, 8'h02);
      chk("al_left_key", {5'd0, evt_key}, 8'd1);
      send(8'h75);
      chk("al_keypad", keys_held, 8'h02);
`else
      send(8'hE0); send(8'h75);
      chk("ext_up_keys", keys_held, 8'h00);
      chk("ext_up_valid", {7'd0, evt_valid}, 8'd0);
      send(8'hE0); send(8'h1D);
      chk("ext_w_keys", keys_held, 8'h00);
      send(8'h75);
      chk("ext_keypad", keys_held, 8'h00);
      send(8'h1D);
      chk("ext_idle_make", keys_held, 8'h01);
      chk("ext_idle_key", {5'd0, evt_key}, 8'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
